goertzel_coef: RTL and testbench

Downstream neighbour of the angle stage in the Goertzel filter bank. For each of NF frequency bins it takes the normalized angle ω (radians, unsigned Q8.24) and computes the Goertzel feedback coefficient 2·cos(ω) using an iterative CORDIC with one micro-rotation per clock. It starts on the angle stage's ready flag and processes the bins sequentially. The finished coefficient array (signed Q3.29) is held stable for the per-bin Goertzel recursion cores.

---
 rtl/goertzel_coef.sv | 200 ++++++++++++++++++++
 tb/tb_goertzel_coef.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/goertzel_coef.sv
// goertzel_coef: per-bin Goertzel feedback coefficient 2*cos(w).
// An iterative rotation-mode CORDIC (one micro-rotation per clock) walks the
// NF bins in order and writes each finished coefficient into a held array.
//
// Ports
//   clk      rising-edge clock
//   rstn     synchronous active-low reset
//   start    level request (angle stage ready); sampled in IDLE
//   angle_i  [NF][32] unsigned Q8.24 radians, stable while busy
//   busy     high while a pass is running
//   ready    high once all NF coefficients of the pass are valid
//   coef_o   [NF][32] signed Q3.29 2*cos(w), registered and held
module goertzel_coef #(
  parameter int unsigned NF   = 11,
  parameter int unsigned ITER = 24
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [NF-1:0][31:0]  angle_i,
  output logic                 busy,
  output logic                 ready,
  output logic [NF-1:0][31:0]  coef_o
);

  localparam int unsigned XW   = 34;  // x/y datapath, Q4.30
  localparam int unsigned ZW   = 32;  // residual angle, Q8.24
  localparam int unsigned RW   = XW + 1;
  localparam int unsigned IDXW = 8;
  localparam int unsigned ITW  = 5;

  localparam logic [ZW-1:0] PI      = 32'h0324_3F6A;
  localparam logic [ZW-1:0] HALF_PI = 32'h0192_1FB5;
  // CORDIC gain compensation 0.607252935 in Q4.30
  localparam logic signed [XW-1:0] K_INIT = 34'sh26DD_3B6A;
  localparam logic [ITW-1:0]  IT_LAST  = ITW'(ITER - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NF - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROT,
    STORE,
    DONE
  } state_t;

  state_t                 state;
  logic [IDXW-1:0]        idx;
  logic [ITW-1:0]         it;
  logic signed [XW-1:0]   x;
  logic signed [XW-1:0]   y;
  logic signed [ZW-1:0]   z;
  logic                   neg;

  logic [ZW-1:0]          a_sel;
  logic [ZW-1:0]          a_clamp;
  logic [ZW-1:0]          fold_z;
  logic                   fold_neg;
  logic signed [XW-1:0]   x_sh;
  logic signed [XW-1:0]   y_sh;
  logic signed [ZW-1:0]   atan_cur;
  logic signed [RW-1:0]   r_ext;
  logic [31:0]            r_sat;

  // atan(2^-i) in Q8.24, rounded; entries past 24 round to zero
  function automatic logic [ZW-1:0] atan_lut(input logic [ITW-1:0] i);
    case (i)
      5'd0:    atan_lut = 32'h00C9_0FDB;
      5'd1:    atan_lut = 32'h0076_B19C;
      5'd2:    atan_lut = 32'h003E_B6EC;
      5'd3:    atan_lut = 32'h001F_D5BB;
      5'd4:    atan_lut = 32'h000F_FAAE;
      5'd5:    atan_lut = 32'h0007_FF55;
      5'd6:    atan_lut = 32'h0003_FFEB;
      5'd7:    atan_lut = 32'h0001_FFFD;
      5'd8:    atan_lut = 32'h0001_0000;
      5'd9:    atan_lut = 32'h0000_8000;
      5'd10:   atan_lut = 32'h0000_4000;
      5'd11:   atan_lut = 32'h0000_2000;
      5'd12:   atan_lut = 32'h0000_1000;
      5'd13:   atan_lut = 32'h0000_0800;
      5'd14:   atan_lut = 32'h0000_0400;
      5'd15:   atan_lut = 32'h0000_0200;
      5'd16:   atan_lut = 32'h0000_0100;
      5'd17:   atan_lut = 32'h0000_0080;
      5'd18:   atan_lut = 32'h0000_0040;
      5'd19:   atan_lut = 32'h0000_0020;
      5'd20:   atan_lut = 32'h0000_0010;
      5'd21:   atan_lut = 32'h0000_0008;
      5'd22:   atan_lut = 32'h0000_0004;
      5'd23:   atan_lut = 32'h0000_0002;
      5'd24:   atan_lut = 32'h0000_0001;
      default: atan_lut = 32'h0000_0000;
    endcase
  endfunction

  // Angle select, clamp to [0, PI] and fold into [0, PI/2]
  always_comb begin
    a_sel = '0;
    for (int unsigned i = 0; i < NF; i++) begin
      if (idx == IDXW'(i)) a_sel = angle_i[i];
    end
    if (a_sel[ZW-1])      a_clamp = '0;
    else if (a_sel > PI)  a_clamp = PI;
    else                  a_clamp = a_sel;
    fold_neg = (a_clamp > HALF_PI);
    fold_z   = fold_neg ? (PI - a_clamp) : a_clamp;
  end

  // Micro-rotation operands
  always_comb begin
    x_sh     = x >>> it;
    y_sh     = y >>> it;
    atan_cur = $signed(atan_lut(it));
  end

  // Unfold sign and saturate to 32-bit signed; Q2.30 cos == Q3.29 2*cos
  always_comb begin
    r_ext = {x[XW-1], x};
    if (neg) r_ext = -r_ext;
    if ((&r_ext[RW-1:31]) || !(|r_ext[RW-1:31])) r_sat = r_ext[31:0];
    else if (r_ext[RW-1])                         r_sat = 32'h8000_0000;
    else                                          r_sat = 32'h7FFF_FFFF;
  end

  // Control FSM and CORDIC datapath
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      idx    <= '0;
      it     <= '0;
      x      <= '0;
      y      <= '0;
      z      <= '0;
      neg    <= 1'b0;
      busy   <= 1'b0;
      ready  <= 1'b0;
      coef_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end

        LOAD: begin
          x     <= K_INIT;
          y     <= '0;
          z     <= $signed(fold_z);
          neg   <= fold_neg;
          it    <= '0;
          state <= ROT;
        end

        ROT: begin
          // d = +1 when residual angle is non-negative
          if (!z[ZW-1]) begin
            x <= x - y_sh;
            y <= y + x_sh;
            z <= z - atan_cur;
          end else begin
            x <= x + y_sh;
            y <= y - x_sh;
            z <= z + atan_cur;
          end
          it <= it + 1'b1;
          if (it == IT_LAST) state <= STORE;
        end

        STORE: begin
          for (int unsigned i = 0; i < NF; i++) begin
            if (idx == IDXW'(i)) coef_o[i] <= r_sat;
          end
          if (idx == IDX_LAST) begin
            state <= DONE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else begin
            idx   <= idx + 1'b1;
            state <= LOAD;
          end
        end

        DONE: begin
          // Rearm only after start has been seen low
          if (!start) begin
            ready <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_goertzel_coef.sv
// Directed bench for goertzel_coef (NF=11, ITER=24).
module tb_goertzel_coef;

  localparam int unsigned NF   = 11;
  localparam int unsigned ITER = 24;
  localparam int unsigned BIN  = ITER + 2;   // 26 cycles per bin
  localparam int unsigned PASS = NF * BIN;   // 286 cycles per pass
  localparam longint      TOL  = 512;

  localparam logic [31:0] C_P1  = 32'h4000_0000;  //  2.0
  localparam logic [31:0] C_HALF= 32'h2000_0000;  //  1.0
  localparam logic [31:0] C_0   = 32'h0000_0000;
  localparam logic [31:0] C_M1  = 32'hC000_0000;  // -2.0

  logic                clk;
  logic                rstn;
  logic                start;
  logic [NF-1:0][31:0] angle_i;
  logic                busy;
  logic                ready;
  logic [NF-1:0][31:0] coef_o;

  int checks;
  int errors;

  goertzel_coef #(.NF(NF), .ITER(ITER)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .angle_i(angle_i),
    .busy   (busy),
    .ready  (ready),
    .coef_o (coef_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; leaves time 1 ns past the last edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic longint sdiff(input logic [31:0] a, input logic [31:0] b);
    return longint'($signed(a)) - longint'($signed(b));
  endfunction

  task automatic test_reset;
    rstn    = 1'b0;
    start   = 1'b1;
    angle_i = '0;
    tick(3);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++;
    if (coef_o !== '0) begin errors++; $display("FAIL reset_coef: got %h expected 0", coef_o); end
    start = 1'b0;
    rstn  = 1'b1;
    tick(3);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_start: busy got %b expected 0", busy); end
  endtask

  task automatic test_known_angles;
    logic [31:0] exp_c [NF];
    bit          chk   [NF];
    angle_i[0]  = 32'h0000_0000;  exp_c[0]  = C_P1;   chk[0]  = 1;
    angle_i[1]  = 32'h010C_1523;  exp_c[1]  = C_HALF; chk[1]  = 1;
    angle_i[2]  = 32'h0192_1FB5;  exp_c[2]  = C_0;    chk[2]  = 1;
    angle_i[3]  = 32'h0324_3F6A;  exp_c[3]  = C_M1;   chk[3]  = 1;
    angle_i[4]  = 32'h8000_0000;  exp_c[4]  = C_P1;   chk[4]  = 1;
    angle_i[5]  = 32'h0500_0000;  exp_c[5]  = C_M1;   chk[5]  = 1;
    angle_i[6]  = 32'h0080_0000;  exp_c[6]  = C_0;    chk[6]  = 0;
    angle_i[7]  = 32'h02A4_3F6A;  exp_c[7]  = C_0;    chk[7]  = 0;
    angle_i[8]  = 32'h0000_0000;  exp_c[8]  = C_P1;   chk[8]  = 1;
    angle_i[9]  = 32'h0324_3F6A;  exp_c[9]  = C_M1;   chk[9]  = 1;
    angle_i[10] = 32'h010C_1523;  exp_c[10] = C_HALF; chk[10] = 1;
    start = 1'b1;
    tick(1);  // E0
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", busy); end
    tick(BIN - 1);  // E0+25
    checks++;
    if (coef_o[0] !== C_0) begin errors++; $display("FAIL bin0_early: got %h expected %h", coef_o[0], C_0); end
    tick(1);  // E0+26
    checks++;
    if (sdiff(coef_o[0], C_P1) > TOL || sdiff(coef_o[0], C_P1) < -TOL) begin
      errors++; $display("FAIL bin0_write_time: got %h expected %h", coef_o[0], C_P1);
    end
    checks++;
    if (coef_o[1] !== C_0) begin errors++; $display("FAIL bin1_held: got %h expected %h", coef_o[1], C_0); end
    tick(PASS - BIN - 1);  // E0+285
    checks++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL pass_early: ready %b busy %b expected ready 0 busy 1", ready, busy);
    end
    tick(1);  // E0+286
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL pass_done: ready %b busy %b expected ready 1 busy 0", ready, busy);
    end
    for (int i = 0; i < NF; i++) begin
      if (chk[i]) begin
        checks++;
        if (sdiff(coef_o[i], exp_c[i]) > TOL || sdiff(coef_o[i], exp_c[i]) < -TOL) begin
          errors++; $display("FAIL coef_bin%0d: got %h expected %h +-512", i, coef_o[i], exp_c[i]);
        end
      end
    end
    // cos(0.5) * 2^30 is about 0x382A....
    checks++;
    if ($signed(coef_o[6]) < 32'sh3700_0000 || $signed(coef_o[6]) > 32'sh3900_0000) begin
      errors++; $display("FAIL coef_half_rad: got %h expected about 382A0000", coef_o[6]);
    end
    checks++;
    if (longint'($signed(coef_o[7])) + longint'($signed(coef_o[6])) > 2 ||
        longint'($signed(coef_o[7])) + longint'($signed(coef_o[6])) < -2) begin
      errors++; $display("FAIL fold_symmetry: got %h expected negation of %h", coef_o[7], coef_o[6]);
    end
  endtask

  task automatic test_rearm;
    // start still high; a changed angle must not be picked up
    angle_i[0] = 32'h0324_3F6A;
    tick(10);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL hold_ready: ready %b busy %b expected ready 1 busy 0", ready, busy);
    end
    checks++;
    if (sdiff(coef_o[0], C_P1) > TOL || sdiff(coef_o[0], C_P1) < -TOL) begin
      errors++; $display("FAIL hold_no_recompute: got %h expected %h", coef_o[0], C_P1);
    end
    start = 1'b0;
    tick(1);
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL rearm_ready_fall: got %b expected 0", ready); end
    start = 1'b1;
    tick(1);  // sample edge
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rearm_busy: got %b expected 1", busy); end
    tick(BIN - 1);
    checks++;
    if (sdiff(coef_o[0], C_P1) > TOL || sdiff(coef_o[0], C_P1) < -TOL) begin
      errors++; $display("FAIL rearm_bin0_early: got %h expected %h", coef_o[0], C_P1);
    end
    tick(1);
    checks++;
    if (sdiff(coef_o[0], C_M1) > TOL || sdiff(coef_o[0], C_M1) < -TOL) begin
      errors++; $display("FAIL rearm_bin0: got %h expected %h", coef_o[0], C_M1);
    end
    tick(PASS - BIN);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL rearm_ready: got %b expected 1", ready); end
  endtask

  task automatic test_start_glitch;
    start = 1'b0;
    tick(1);
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL glitch_prep_ready: got %b expected 0", ready); end
    angle_i[0] = 32'h0000_0000;
    start = 1'b1;
    tick(1);   // E0
    tick(99);  // E0+99
    start = 1'b0;
    tick(5);   // E0+104
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy: got %b expected 1", busy); end
    start = 1'b1;
    tick(170); // E0+274
    start = 1'b0;
    tick(11);  // E0+285
    checks++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL glitch_early: ready %b busy %b expected ready 0 busy 1", ready, busy);
    end
    tick(1);   // E0+286
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL glitch_done: ready %b busy %b expected ready 1 busy 0", ready, busy);
    end
    checks++;
    if (sdiff(coef_o[0], C_P1) > TOL || sdiff(coef_o[0], C_P1) < -TOL) begin
      errors++; $display("FAIL glitch_bin0: got %h expected %h", coef_o[0], C_P1);
    end
    tick(1);
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL glitch_ready_fall: got %b expected 0", ready); end
  endtask

  task automatic test_reset_mid_pass;
    start = 1'b1;
    tick(1);   // E0
    tick(99);  // E0+99
    rstn = 1'b0;
    tick(1);   // E0+100
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL midreset_flags: busy %b ready %b expected 0 0", busy, ready);
    end
    checks++;
    if (coef_o !== '0) begin errors++; $display("FAIL midreset_coef: got %h expected 0", coef_o); end
    rstn = 1'b1;
    tick(1);   // first edge with rstn high samples start
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midreset_restart: busy %b expected 1", busy); end
    tick(PASS - 1);
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL midreset_early: ready %b expected 0", ready); end
    tick(1);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_done: ready %b busy %b expected ready 1 busy 0", ready, busy);
    end
    checks++;
    if (sdiff(coef_o[1], C_HALF) > TOL || sdiff(coef_o[1], C_HALF) < -TOL) begin
      errors++; $display("FAIL midreset_bin1: got %h expected %h", coef_o[1], C_HALF);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rstn    = 1'b0;
    start   = 1'b0;
    angle_i = '0;
    test_reset();
    test_known_angles();
    test_rearm();
    test_start_glitch();
    test_reset_mid_pass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
